// File: rtl/usr_reg_rd_initiator.sv
// rtl/usr_reg_rd_initiator.sv - host-side initiator for the user register read path
//
// Accepts one host read request at a time, issues a single-cycle read strobe
// with a held address, waits RD_WAIT cycles for the read switch data to
// settle, samples it and holds it as a response until the host takes it.
//
// Optional feature macro: USR_REG_RD_ALIGN_CHK_EN
//   defined   : misaligned addresses (addr[1:0] != 0) get an immediate error
//               response with no strobe.
//   undefined : err is constant 0 and the address low bits are forced to 0.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_host_rd_valid    host read request valid
//   o_host_rd_ready    request accepted on valid & ready (IDLE and not in reset)
//   i_host_rd_addr     request byte address
//   o_host_rsp_valid   response valid, held until i_host_rsp_ready
//   i_host_rsp_ready   host accepts the response
//   o_host_rsp_data    read data
//   o_host_rsp_err     misaligned-address error
//   o_usr_reg_rd       one-cycle read strobe toward the read switch
//   o_usr_reg_addr     read address, held from acceptance to next acceptance
//   i_usr_reg_data     registered data from the read switch
//   o_busy             high whenever not IDLE
module usr_reg_rd_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WAIT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_host_rd_valid,
  output logic                  o_host_rd_ready,
  input  logic [ADDR_WIDTH-1:0] i_host_rd_addr,
  output logic                  o_host_rsp_valid,
  input  logic                  i_host_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_host_rsp_data,
  output logic                  o_host_rsp_err,
  output logic                  o_usr_reg_rd,
  output logic [ADDR_WIDTH-1:0] o_usr_reg_addr,
  input  logic [DATA_WIDTH-1:0] i_usr_reg_data,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Counter starts at RD_WAIT-1 in the cycle after the strobe, so the sample
  // edge lands RD_WAIT cycles after the strobe cycle.
  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  rd_fire;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] addr_cap;

  assign o_host_rd_ready = (state == S_IDLE) & ~rst;
  assign rd_fire         = i_host_rd_valid & o_host_rd_ready;
  assign o_usr_reg_rd    = (state == S_ISSUE);
  assign o_busy          = (state != S_IDLE);

`ifdef USR_REG_RD_ALIGN_CHK_EN
  assign misaligned = |i_host_rd_addr[1:0];
  assign addr_cap   = i_host_rd_addr;
`else
  // Word-aligned accesses only: drop the byte offset rather than reject it.
  assign misaligned = 1'b0;
  assign addr_cap   = i_host_rd_addr & ~ADDR_WIDTH'(3);
`endif

`ifdef USR_REG_RD_ALIGN_CHK_EN
  logic err_q;
  assign o_host_rsp_err = err_q;
`else
  assign o_host_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      wait_cnt         <= 4'd0;
      o_host_rsp_valid <= 1'b0;
      o_host_rsp_data  <= '0;
      o_usr_reg_addr   <= '0;
`ifdef USR_REG_RD_ALIGN_CHK_EN
      err_q            <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_fire) begin
            o_usr_reg_addr <= addr_cap;
            if (misaligned) begin
              // Error response straight away; the read switch is never touched.
              o_host_rsp_valid <= 1'b1;
              o_host_rsp_data  <= '0;
`ifdef USR_REG_RD_ALIGN_CHK_EN
              err_q            <= 1'b1;
`endif
              state            <= S_RESP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            o_host_rsp_data  <= i_usr_reg_data;
            o_host_rsp_valid <= 1'b1;
`ifdef USR_REG_RD_ALIGN_CHK_EN
            err_q            <= 1'b0;
`endif
            state            <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Data and err are left at their last values after the handshake.
          if (i_host_rsp_ready) begin
            o_host_rsp_valid <= 1'b0;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
